// File: rtl/vga_pkg.sv
// Shared VGA timing definitions for the dino game video path.
// Holds the default 640x480@60 timing, the derived totals and sync windows,
// the counter type and the registered output bundle of vga_sync_gen.
package vga_pkg;

  // Pixel and line counters are 10 bits wide, which covers 0..799 and 0..524.
  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Default horizontal timing, in pixels.
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  // Default vertical timing, in lines.
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync windows as half-open ranges [start, end): 656..751 and 490..491.
  localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  // Everything the renderer sees, registered together so it stays aligned.
  typedef struct packed {
    cnt_t x;
    cnt_t y;
    logic hsync;
    logic vsync;
    logic video_on;
    logic frame_start;
    logic game_update;
  } sync_out_t;

  // Idle state: origin, both syncs deasserted (high), no video, no pulses.
  localparam sync_out_t SYNC_OUT_RESET = '{
    x:           '0,
    y:           '0,
    hsync:       1'b1,
    vsync:       1'b1,
    video_on:    1'b0,
    frame_start: 1'b0,
    game_update: 1'b0
  };

  // True when lo <= c < hi.
  function automatic logic in_window(input cnt_t c, input cnt_t lo, input cnt_t hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a slow level that is sampled as data in the clk
// domain. The history register clears on reset, so a level that is already
// high when reset releases produces exactly one rise.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;

  // Remember the level from the previous clk.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst) din_q <= 1'b0;
    else      din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA 640x480 timing generator with frame-synchronous game-update gating.
// Turns the divider's vga_clk / game_tick levels into one-clk strobes,
// runs the pixel/line counters on the pixel strobe, decodes registered
// sync/video signals, and releases pending game ticks only when the raster
// enters vertical blanking so sprites never tear.
// Optional feature: define DINO_TICK_OVERRUN_EN to build the sticky
// tick_overrun detector; otherwise tick_overrun is tied low.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vga_clk,
  input  logic       game_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start,
  output logic       game_update,
  output logic       tick_overrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_VIS    = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  // ---------------------------------------------------------------------
  // Strobes from the divided levels
  // ---------------------------------------------------------------------
  logic pix_en;
  logic tick_rise;

  rise_detect u_pix_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (vga_clk),
    .rise (pix_en)
  );

  rise_detect u_tick_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (game_tick),
    .rise (tick_rise)
  );

  // ---------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------
  cnt_t h_cnt, h_nxt;
  cnt_t v_cnt, v_nxt;
  logic cnt_moved;   // counters changed on the previous edge

  // Advance one pixel per pix_en, wrapping at line and frame ends.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_nxt = h_cnt + 1'b1;
      end
    end
  end

  // Counter registers; a frozen vga_clk simply holds them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      cnt_moved <= 1'b0;
    end else begin
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;
      cnt_moved <= pix_en;
    end
  end

  // ---------------------------------------------------------------------
  // Game-tick gating
  // ---------------------------------------------------------------------
  logic pending, pending_nxt;
  logic release_now;
  logic at_origin;
  logic at_vblank;

  // The counters only reach h=0 by wrapping, so "just moved and now at h=0"
  // identifies the clk in which the raster entered a new line.
  assign at_origin = cnt_moved && (h_cnt == '0) && (v_cnt == '0);
  assign at_vblank = cnt_moved && (h_cnt == '0) && (v_cnt == V_VIS);

  // Release the single pending tick on entry to vertical blanking; a rise in
  // the release clk re-arms pending so that tick is carried to next frame.
  always_comb begin
    release_now = at_vblank && pending;
    pending_nxt = tick_rise | (pending & ~release_now);
  end

  // Pending tick flag; extra rises while set coalesce into it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending <= 1'b0;
    else      pending <= pending_nxt;
  end

`ifdef DINO_TICK_OVERRUN_EN
  logic overrun_q;

  // Sticky: a tick arrived while one was still waiting and none left.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                      overrun_q <= 1'b0;
    else if (tick_rise && pending && !release_now) overrun_q <= 1'b1;
  end

  assign tick_overrun = overrun_q;
`else
  assign tick_overrun = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Registered decode
  // ---------------------------------------------------------------------
  sync_out_t out_d, out_q;

  // Decode the current counters into the next output bundle.
  always_comb begin
    out_d             = SYNC_OUT_RESET;
    out_d.x           = h_cnt;
    out_d.y           = v_cnt;
    out_d.hsync       = ~in_window(h_cnt, HS_START, HS_END);
    out_d.vsync       = ~in_window(v_cnt, VS_START, VS_END);
    out_d.video_on    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    out_d.frame_start = at_origin;
    out_d.game_update = release_now;
  end

  // One register stage for all outputs keeps them mutually aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_q <= SYNC_OUT_RESET;
    else      out_q <= out_d;
  end

  assign x           = out_q.x;
  assign y           = out_q.y;
  assign hsync       = out_q.hsync;
  assign vsync       = out_q.vsync;
  assign video_on    = out_q.video_on;
  assign frame_start = out_q.frame_start;
  assign game_update = out_q.game_update;

endmodule
